// File: rtl/ariane_pkg.sv
// Shared frontend types: the RAS entry and the state encoding of the commit-side repair FSM.
package ariane_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] ra;
    } ras_t;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        REPLAY
    } ras_repair_state_e;

endpackage

// File: rtl/ras_arch_stack.sv
// Architectural (committed) copy of the return address stack; entry 0 is the top.
module ras_arch_stack
    import ariane_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1),
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             call_i,
    input  logic             ret_i,
    input  logic [63:0]      ra_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [63:0]      rd_ra_o,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    ras_t             stack_q [DEPTH];
    ras_t             stack_d [DEPTH];
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        stack_d = stack_q;
        cnt_d   = cnt_q;
        if (call_i && ret_i) begin
            // A call paired with a return only swaps the top; an empty stack gains it.
            stack_d[0] = ras_t'{valid: 1'b1, ra: ra_i};
            if (cnt_q == '0) cnt_d = CNT_W'(1);
        end else if (call_i) begin
            for (int i = DEPTH - 1; i > 0; i--) stack_d[i] = stack_q[i-1];
            stack_d[0] = ras_t'{valid: 1'b1, ra: ra_i};
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        end else if (ret_i && cnt_q != '0) begin
            for (int i = 0; i < DEPTH - 1; i++) stack_d[i] = stack_q[i+1];
            stack_d[DEPTH-1] = '0;
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // NOTE: this is a handful of flops, not a RAM, and must read back as zero after
    // reset, so every entry is reset; a real memory array would be left unreset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
            cnt_q <= '0;
        end else begin
            stack_q <= stack_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rd_ra_o = stack_q[rd_idx_i].ra;
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/ras_repair.sv
// Commit-side RAS repair: flushes the speculative RAS and replays the committed stack bottom-first.
// Optional statistics counters are built when RAS_REPAIR_STATS_EN is defined.
module ras_repair
    import ariane_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        commit_call_i,
    input  logic        commit_ret_i,
    input  logic [63:0] commit_ra_i,
    input  logic        repair_i,
    input  logic        fe_push_i,
    input  logic        fe_pop_i,
    input  logic [63:0] fe_data_i,
    output logic        ras_flush_o,
    output logic        ras_push_o,
    output logic        ras_pop_o,
    output logic [63:0] ras_data_o,
    output logic        stall_fe_o,
    output logic        busy_o,
    output logic        done_o
`ifdef RAS_REPAIR_STATS_EN
   ,output logic [31:0] repair_cnt_o,
    output logic [31:0] overflow_cnt_o
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    ras_repair_state_e state_q, state_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic              dirty_q, dirty_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  arch_cnt;
    logic [63:0]       arch_ra;
    logic              commit_any;
    logic              busy;

    assign commit_any = commit_call_i | commit_ret_i;
    assign busy       = (state_q != IDLE);

    ras_arch_stack #(
        .DEPTH (DEPTH)
    ) i_arch_stack (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .call_i   (commit_call_i),
        .ret_i    (commit_ret_i),
        .ra_i     (commit_ra_i),
        .rd_idx_i (IDX_W'(idx_q - CNT_W'(1))),
        .rd_ra_o  (arch_ra),
        .cnt_o    (arch_cnt)
    );

    // NOTE: every signal driven here gets its default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        dirty_d     = dirty_q | (busy & commit_any);
        done_d      = 1'b0;
        ras_flush_o = 1'b0;
        ras_push_o  = 1'b0;
        ras_pop_o   = 1'b0;
        ras_data_o  = '0;

        // Wherever idx is loaded from the count, a commit in that same cycle is not yet
        // visible in arch_cnt, so it marks the new replay dirty instead of being lost.
        unique case (state_q)
            IDLE: begin
                ras_push_o = fe_push_i;
                ras_pop_o  = fe_pop_i;
                ras_data_o = fe_data_i;
                if (repair_i) begin
                    state_d = CLEAR;
                    idx_d   = arch_cnt;
                    dirty_d = commit_any;
                end
            end
            CLEAR: begin
                ras_flush_o = 1'b1;
                if (idx_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = REPLAY;
                end
            end
            REPLAY: begin
                ras_push_o = 1'b1;
                ras_data_o = arch_ra;
                idx_d      = idx_q - CNT_W'(1);
                if (idx_q == CNT_W'(1)) begin
                    if (dirty_q || commit_any) begin
                        state_d = CLEAR;
                        idx_d   = arch_cnt;
                        dirty_d = commit_any;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (repair_i && busy) begin
            state_d = CLEAR;
            idx_d   = arch_cnt;
            dirty_d = commit_any;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            dirty_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dirty_q <= dirty_d;
            done_q  <= done_d;
        end
    end

    assign busy_o     = busy;
    assign stall_fe_o = busy;
    assign done_o     = done_q;

`ifdef RAS_REPAIR_STATS_EN
    logic [31:0] repair_cnt_q, repair_cnt_d;
    logic [31:0] overflow_cnt_q, overflow_cnt_d;

    always_comb begin
        repair_cnt_d   = repair_cnt_q;
        overflow_cnt_d = overflow_cnt_q;
        if (repair_i && repair_cnt_q != '1) repair_cnt_d = repair_cnt_q + 32'd1;
        if (commit_call_i && arch_cnt == CNT_W'(DEPTH) && overflow_cnt_q != '1)
            overflow_cnt_d = overflow_cnt_q + 32'd1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            repair_cnt_q   <= '0;
            overflow_cnt_q <= '0;
        end else begin
            repair_cnt_q   <= repair_cnt_d;
            overflow_cnt_q <= overflow_cnt_d;
        end
    end

    assign repair_cnt_o   = repair_cnt_q;
    assign overflow_cnt_o = overflow_cnt_q;
`endif

endmodule

// File: tb/tb_ras_repair.sv
// Directed bench for ras_repair (DEPTH=2): replay order, latency, saturation, dirty restart, reset.
module tb_ras_repair;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        commit_call, commit_ret, repair;
    logic [63:0] commit_ra;
    logic        fe_push, fe_pop;
    logic [63:0] fe_data;
    logic        ras_flush, ras_push, ras_pop, stall_fe, busy, done;
    logic [63:0] ras_data;
`ifdef RAS_REPAIR_STATS_EN
    logic [31:0] repair_cnt, overflow_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ras_repair #(.DEPTH(2)) dut (
        .clk_i          (clk),
`ifdef RAS_REPAIR_STATS_EN
        .repair_cnt_o   (repair_cnt),
        .overflow_cnt_o (overflow_cnt),
`endif
        .rst_ni         (rst_n),
        .commit_call_i  (commit_call),
        .commit_ret_i   (commit_ret),
        .commit_ra_i    (commit_ra),
        .repair_i       (repair),
        .fe_push_i      (fe_push),
        .fe_pop_i       (fe_pop),
        .fe_data_i      (fe_data),
        .ras_flush_o    (ras_flush),
        .ras_push_o     (ras_push),
        .ras_pop_o      (ras_pop),
        .ras_data_o     (ras_data),
        .stall_fe_o     (stall_fe),
        .busy_o         (busy),
        .done_o         (done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Step to just after the next rising edge and drop all single-cycle requests.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        commit_call = 1'b0;
        commit_ret  = 1'b0;
        repair      = 1'b0;
        fe_push     = 1'b0;
        fe_pop      = 1'b0;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        commit_call = 1'b0; commit_ret = 1'b0; commit_ra = '0;
        repair = 1'b0; fe_push = 1'b0; fe_pop = 1'b0; fe_data = '0;

        // Reset state
        next_cycle(); next_cycle(); sample();
        check("rst_flush", ras_flush, 0);
        check("rst_push",  ras_push,  0);
        check("rst_pop",   ras_pop,   0);
        check("rst_data",  ras_data,  0);
        check("rst_stall", stall_fe,  0);
        check("rst_busy",  busy,      0);
        check("rst_done",  done,      0);
        rst_n = 1'b1;

        // Calls 0x100, 0x200 then repair: flush t+1, push 0x100 t+2, 0x200 t+3, done t+4
        next_cycle(); commit_call = 1'b1; commit_ra = 64'h100;
        next_cycle(); commit_call = 1'b1; commit_ra = 64'h200;
        next_cycle(); repair = 1'b1; sample();
        check("t1_t0_busy", busy, 0);
        next_cycle(); sample();
        check("t1_flush",  ras_flush, 1);
        check("t1_busy1",  busy,      1);
        check("t1_stall1", stall_fe,  1);
        check("t1_nopush", ras_push,  0);
        next_cycle(); sample();
        check("t1_push0",  ras_push,  1);
        check("t1_data0",  ras_data,  64'h100);
        check("t1_flush0", ras_flush, 0);
        check("t1_nopop",  ras_pop,   0);
        next_cycle(); sample();
        check("t1_push1",  ras_push,  1);
        check("t1_data1",  ras_data,  64'h200);
        check("t1_busy3",  busy,      1);
        check("t1_early",  done,      0);
        next_cycle(); sample();
        check("t1_done",   done,      1);
        check("t1_idle",   busy,      0);
        check("t1_push_end", ras_push, 0);
        next_cycle(); sample();
        check("t1_done_1cyc", done, 0);

        // Overflow: calls 0x1, 0x2, 0x3 from empty keep only 0x2 (bottom) and 0x3 (top)
        do_reset();
        commit_call = 1'b1; commit_ra = 64'h1;
        next_cycle(); commit_call = 1'b1; commit_ra = 64'h2;
        next_cycle(); commit_call = 1'b1; commit_ra = 64'h3;
        next_cycle(); repair = 1'b1;
        next_cycle(); sample();
        check("t2_flush", ras_flush, 1);
        next_cycle(); sample();
        check("t2_push0", ras_push, 1);
        check("t2_data0", ras_data, 64'h2);
        next_cycle(); sample();
        check("t2_push1", ras_push, 1);
        check("t2_data1", ras_data, 64'h3);
        next_cycle(); sample();
        check("t2_done", done, 1);
`ifdef RAS_REPAIR_STATS_EN
        check("t2_overflow_cnt", overflow_cnt, 1);
        check("t2_repair_cnt",   repair_cnt,   1);
`endif

        // Empty stack: two returns drain it, a third is a no-op; repair has no pushes
        next_cycle(); commit_ret = 1'b1;
        next_cycle(); commit_ret = 1'b1;
        next_cycle(); commit_ret = 1'b1;
        next_cycle(); repair = 1'b1;
        next_cycle(); sample();
        check("t3_flush", ras_flush, 1);
        check("t3_busy",  busy,      1);
        next_cycle(); sample();
        check("t3_done",   done,     1);
        check("t3_nopush", ras_push, 0);
        check("t3_idle",   busy,     0);

        // Stack {top 0x10, bottom 0x20}; call+return 0xA0 replaces the top only
        next_cycle(); commit_call = 1'b1; commit_ra = 64'h20;
        next_cycle(); commit_call = 1'b1; commit_ra = 64'h10;
        next_cycle(); commit_call = 1'b1; commit_ret = 1'b1; commit_ra = 64'hA0;
        next_cycle(); repair = 1'b1;
        next_cycle(); sample();
        check("t4_flush", ras_flush, 1);
        next_cycle(); sample();
        check("t4_data0", ras_data, 64'h20);
        next_cycle(); sample();
        check("t4_data1", ras_data, 64'hA0);
        next_cycle(); sample();
        check("t4_done", done, 1);

        // Commit call 0x300 during REPLAY: restart and replay {0xA0, 0x300}, single done
        next_cycle(); repair = 1'b1;
        next_cycle(); sample();
        check("t5_flush_a", ras_flush, 1);
        next_cycle(); commit_call = 1'b1; commit_ra = 64'h300; sample();
        check("t5_data0", ras_data, 64'h20);
        next_cycle(); sample();
        check("t5_data1",  ras_data, 64'h300);
        check("t5_nodone1", done,    0);
        next_cycle(); sample();
        check("t5_flush_b", ras_flush, 1);
        check("t5_busy_b",  busy,      1);
        check("t5_nodone2", done,      0);
        next_cycle(); sample();
        check("t5_data2",   ras_data, 64'hA0);
        check("t5_nodone3", done,     0);
        next_cycle(); sample();
        check("t5_data3",   ras_data, 64'h300);
        check("t5_nodone4", done,     0);
        next_cycle(); sample();
        check("t5_done", done, 1);
        next_cycle(); sample();
        check("t5_done_once", done, 0);

        // IDLE pass-through, then frontend ignored while busy
        next_cycle(); fe_push = 1'b1; fe_data = 64'h55; sample();
        check("t6_pt_push",  ras_push, 1);
        check("t6_pt_data",  ras_data, 64'h55);
        check("t6_pt_stall", stall_fe, 0);
        next_cycle(); fe_pop = 1'b1; sample();
        check("t6_pt_pop",    ras_pop,  1);
        check("t6_pt_nopush", ras_push, 0);
        next_cycle(); repair = 1'b1;
        next_cycle(); fe_push = 1'b1; fe_pop = 1'b1; fe_data = 64'h77; sample();
        check("t6_blk_push",  ras_push,  0);
        check("t6_blk_pop",   ras_pop,   0);
        check("t6_blk_flush", ras_flush, 1);
        check("t6_blk_stall", stall_fe,  1);

        // Reset mid-REPLAY: reset outputs on the next cycle, no done pulse
        next_cycle(); sample();
        check("t7_replay_data", ras_data, 64'hA0);
        rst_n = 1'b0;
        next_cycle(); sample();
        check("t7_busy",  busy,      0);
        check("t7_push",  ras_push,  0);
        check("t7_flush", ras_flush, 0);
        check("t7_stall", stall_fe,  0);
        check("t7_done",  done,      0);
        rst_n = 1'b1;
        next_cycle(); repair = 1'b1; sample();
        check("t7_nodone_after", done, 0);
        // Architectural stack was cleared by reset: repair finishes with no pushes
        next_cycle(); sample();
        check("t7_flush2", ras_flush, 1);
        next_cycle(); sample();
        check("t7_done2",   done,     1);
        check("t7_nopush2", ras_push, 0);
`ifdef RAS_REPAIR_STATS_EN
        check("t7_repair_cnt", repair_cnt, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
